// File: rtl/hazard_control_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : hazard_control_unit_if
// Description : Pipeline-to-hazard-unit bundle. Carries the ID/EX/MEM
//               register-field observations into the hazard unit and the
//               stall/bubble/flush controls plus status back out.
//               master : pipeline side (drives observations, reads controls)
//               slave  : hazard unit side (reads observations, drives controls)
// Revision    : 1.0 - initial release
// ============================================================================
interface hazard_control_unit_if #(
    parameter int CNT_WIDTH = 16
);
    // Observations from the pipeline registers
    logic [4:0]           IF_ID_rs;
    logic [4:0]           IF_ID_rt;
    logic                 IF_ID_uses_rt;
    logic                 IF_ID_is_branch;
    logic                 ID_branch_taken;
    logic                 ID_jump;
    logic                 ID_EX_mem_read;
    logic                 ID_EX_reg_write;
    logic [4:0]           ID_EX_write_register;
    logic                 ID_EX_muldiv;
    logic                 EX_ME_mem_read;
    logic [4:0]           EX_ME_write_register;

    // Controls and status from the hazard unit
    logic                 pc_write;
    logic                 IF_ID_write;
    logic                 IF_ID_flush;
    logic                 ID_EX_bubble;
    logic                 ID_EX_write;
    logic                 EX_ME_bubble;
    logic                 muldiv_busy;
    logic [CNT_WIDTH-1:0] stall_cycles;

    modport master (
        output IF_ID_rs, IF_ID_rt, IF_ID_uses_rt, IF_ID_is_branch,
               ID_branch_taken, ID_jump, ID_EX_mem_read, ID_EX_reg_write,
               ID_EX_write_register, ID_EX_muldiv, EX_ME_mem_read,
               EX_ME_write_register,
        input  pc_write, IF_ID_write, IF_ID_flush, ID_EX_bubble,
               ID_EX_write, EX_ME_bubble, muldiv_busy, stall_cycles
    );

    modport slave (
        input  IF_ID_rs, IF_ID_rt, IF_ID_uses_rt, IF_ID_is_branch,
               ID_branch_taken, ID_jump, ID_EX_mem_read, ID_EX_reg_write,
               ID_EX_write_register, ID_EX_muldiv, EX_ME_mem_read,
               EX_ME_write_register,
        output pc_write, IF_ID_write, IF_ID_flush, ID_EX_bubble,
               ID_EX_write, EX_ME_bubble, muldiv_busy, stall_cycles
    );
endinterface
`default_nettype wire

// File: rtl/hazard_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : hazard_control_unit
// Description : Detects hazards the EX forwarding network cannot cover in the
//               5-stage MIPS pipeline (load-use, branch operand dependencies
//               for branches resolved in ID, multi-cycle mult/div occupancy
//               of EX) and generates stall, bubble and flush controls.
//               Also keeps a saturating count of cycles with the PC frozen.
// Ports       : clk   - system clock, rising edge
//               reset - synchronous, active-high
//               bus   - hazard_control_unit_if.slave (observations in,
//                       pc_write/IF_ID_write/IF_ID_flush/ID_EX_bubble/
//                       ID_EX_write/EX_ME_bubble/muldiv_busy/stall_cycles out)
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_control_unit #(
    parameter int MULDIV_LATENCY = 4,
    parameter int CNT_WIDTH      = 16
) (
    input  wire logic             clk,
    input  wire logic             reset,
    hazard_control_unit_if.slave  bus
);

    // Down-counter only needs to hold MULDIV_LATENCY-2; keep at least 1 bit.
    localparam int c_MD_CNT_W = (MULDIV_LATENCY > 3) ? $clog2(MULDIV_LATENCY - 1) : 1;
    localparam int c_MD_INIT  = (MULDIV_LATENCY >= 2) ? (MULDIV_LATENCY - 2) : 0;
    localparam logic [c_MD_CNT_W-1:0] c_MD_CNT_INIT = c_MD_CNT_W'(c_MD_INIT);
    // With single-cycle mult/div there is no occupancy to cover.
    localparam logic c_MD_EN = (MULDIV_LATENCY >= 2);

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

    md_state_t              r_state;
    md_state_t              w_state_nxt;
    logic [c_MD_CNT_W-1:0]  r_md_cnt;
    logic [c_MD_CNT_W-1:0]  w_md_cnt_nxt;
    logic                   w_md_stall;
    logic [CNT_WIDTH-1:0]   r_stall_cycles;

    logic w_ex_match;
    logic w_me_match;
    logic w_ld_hz;
    logic w_br_alu_hz;
    logic w_br_ld_hz;
    logic w_hz;

    logic w_pc_write;
    logic w_if_id_write;
    logic w_if_id_flush;
    logic w_id_ex_bubble;
    logic w_id_ex_write;
    logic w_ex_me_bubble;

    // ------------------------------------------------------------------
    // Source match: $zero never creates a dependency; rt only counts when
    // the ID instruction actually reads it.
    // ------------------------------------------------------------------
    assign w_ex_match = (bus.ID_EX_write_register != 5'd0) &&
                        ((bus.ID_EX_write_register == bus.IF_ID_rs) ||
                         (bus.IF_ID_uses_rt && (bus.ID_EX_write_register == bus.IF_ID_rt)));

    assign w_me_match = (bus.EX_ME_write_register != 5'd0) &&
                        ((bus.EX_ME_write_register == bus.IF_ID_rs) ||
                         (bus.IF_ID_uses_rt && (bus.EX_ME_write_register == bus.IF_ID_rt)));

    // A load feeding a branch trips ld_hz first, then br_ld_hz once it
    // reaches MEM, giving the two-cycle branch-after-load stall.
    assign w_ld_hz     = bus.ID_EX_mem_read && w_ex_match;
    assign w_br_alu_hz = bus.IF_ID_is_branch && bus.ID_EX_reg_write && w_ex_match;
    assign w_br_ld_hz  = bus.IF_ID_is_branch && bus.EX_ME_mem_read && w_me_match;
    assign w_hz        = w_ld_hz | w_br_alu_hz | w_br_ld_hz;

    // ------------------------------------------------------------------
    // Mult/div occupancy FSM: next state and md_stall
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_md_cnt_nxt = r_md_cnt;
        w_md_stall   = 1'b0;
        case (r_state)
            RUN: begin
                if (c_MD_EN && bus.ID_EX_muldiv) begin
                    w_md_stall   = 1'b1;
                    w_state_nxt  = MD_BUSY;
                    w_md_cnt_nxt = c_MD_CNT_INIT;
                end
            end
            MD_BUSY: begin
                // cnt==0 is the final EX cycle: let the pipeline advance.
                if (r_md_cnt != '0) begin
                    w_md_stall   = 1'b1;
                    w_md_cnt_nxt = r_md_cnt - c_MD_CNT_W'(1);
                end else begin
                    w_state_nxt  = RUN;
                end
            end
            default: begin
                w_state_nxt  = RUN;
                w_md_cnt_nxt = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Control outputs. Mult/div stall dominates the hazard stall; a branch
    // or jump is only acted on when nothing is stalling.
    // ------------------------------------------------------------------
    always_comb begin
        w_pc_write     = 1'b1;
        w_if_id_write  = 1'b1;
        w_if_id_flush  = 1'b0;
        w_id_ex_bubble = 1'b0;
        w_id_ex_write  = 1'b1;
        w_ex_me_bubble = 1'b0;
        if (!reset) begin
            if (w_md_stall) begin
                // Freeze IF/ID/EX, drain NOPs into MEM behind the mult/div.
                w_pc_write     = 1'b0;
                w_if_id_write  = 1'b0;
                w_id_ex_write  = 1'b0;
                w_ex_me_bubble = 1'b1;
            end else if (w_hz) begin
                // Hold IF/ID, inject a NOP into EX.
                w_pc_write     = 1'b0;
                w_if_id_write  = 1'b0;
                w_id_ex_bubble = 1'b1;
            end else begin
                w_if_id_flush  = (bus.IF_ID_is_branch && bus.ID_branch_taken) || bus.ID_jump;
            end
        end
    end

    // ------------------------------------------------------------------
    // State register and saturating stall-cycle counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= RUN;
            r_md_cnt       <= '0;
            r_stall_cycles <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_md_cnt <= w_md_cnt_nxt;
            if (!w_pc_write && (r_stall_cycles != {CNT_WIDTH{1'b1}})) begin
                r_stall_cycles <= r_stall_cycles + CNT_WIDTH'(1);
            end
        end
    end

    assign bus.pc_write     = w_pc_write;
    assign bus.IF_ID_write  = w_if_id_write;
    assign bus.IF_ID_flush  = w_if_id_flush;
    assign bus.ID_EX_bubble = w_id_ex_bubble;
    assign bus.ID_EX_write  = w_id_ex_write;
    assign bus.EX_ME_bubble = w_ex_me_bubble;
    assign bus.muldiv_busy  = (r_state == MD_BUSY);
    assign bus.stall_cycles = r_stall_cycles;

endmodule
`default_nettype wire

// File: tb/tb_hazard_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_control_unit
// Description : Self-checking bench for hazard_control_unit. Directed steps
//               followed by randomized traffic, all outputs compared every
//               cycle against a behavioural reference model. A second
//               instance with a 4-bit counter shares the stimulus to check
//               counter saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_control_unit;

    localparam int LAT = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hazard_control_unit_if #(.CNT_WIDTH(16)) bus ();
    hazard_control_unit_if #(.CNT_WIDTH(4))  bus4 ();

    assign bus4.IF_ID_rs             = bus.IF_ID_rs;
    assign bus4.IF_ID_rt             = bus.IF_ID_rt;
    assign bus4.IF_ID_uses_rt        = bus.IF_ID_uses_rt;
    assign bus4.IF_ID_is_branch      = bus.IF_ID_is_branch;
    assign bus4.ID_branch_taken      = bus.ID_branch_taken;
    assign bus4.ID_jump              = bus.ID_jump;
    assign bus4.ID_EX_mem_read       = bus.ID_EX_mem_read;
    assign bus4.ID_EX_reg_write      = bus.ID_EX_reg_write;
    assign bus4.ID_EX_write_register = bus.ID_EX_write_register;
    assign bus4.ID_EX_muldiv         = bus.ID_EX_muldiv;
    assign bus4.EX_ME_mem_read       = bus.EX_ME_mem_read;
    assign bus4.EX_ME_write_register = bus.EX_ME_write_register;

    hazard_control_unit #(.MULDIV_LATENCY(LAT), .CNT_WIDTH(16)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    hazard_control_unit #(.MULDIV_LATENCY(LAT), .CNT_WIDTH(4)) u_sat (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4.slave)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state: remaining cycles the unit sits in its busy
    // state, and the plain count of frozen-PC cycles since reset.
    int m_md_left = 0;
    int m_stalls  = 0;

    logic e_pc, e_ifid_w, e_flush, e_idex_bub, e_idex_w, e_exme_bub, e_busy;

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic checkn(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic bit depends(input logic [4:0] r, input logic [4:0] rs,
                                   input logic [4:0] rt, input logic uses_rt);
        return (r != 5'd0) && ((r == rs) || (uses_rt && (r == rt)));
    endfunction

    task automatic model_eval();
        bit md_stall;
        bit ex_dep;
        bit me_dep;
        bit hz;
        if (m_md_left == 0) md_stall = (LAT >= 2) && bus.ID_EX_muldiv;
        else                md_stall = (m_md_left > 1);
        ex_dep = depends(bus.ID_EX_write_register, bus.IF_ID_rs, bus.IF_ID_rt, bus.IF_ID_uses_rt);
        me_dep = depends(bus.EX_ME_write_register, bus.IF_ID_rs, bus.IF_ID_rt, bus.IF_ID_uses_rt);
        hz = (bus.ID_EX_mem_read && ex_dep) ||
             (bus.IF_ID_is_branch && bus.ID_EX_reg_write && ex_dep) ||
             (bus.IF_ID_is_branch && bus.EX_ME_mem_read && me_dep);
        e_busy     = (m_md_left > 0);
        e_pc       = 1'b1;
        e_ifid_w   = 1'b1;
        e_flush    = 1'b0;
        e_idex_bub = 1'b0;
        e_idex_w   = 1'b1;
        e_exme_bub = 1'b0;
        if (!reset) begin
            if (md_stall) begin
                e_pc = 1'b0; e_ifid_w = 1'b0; e_idex_w = 1'b0; e_exme_bub = 1'b1;
            end else if (hz) begin
                e_pc = 1'b0; e_ifid_w = 1'b0; e_idex_bub = 1'b1;
            end else begin
                e_flush = (bus.IF_ID_is_branch && bus.ID_branch_taken) || bus.ID_jump;
            end
        end
    endtask

    task automatic model_advance();
        if (reset) begin
            m_md_left = 0;
            m_stalls  = 0;
        end else begin
            if (!e_pc) m_stalls++;
            if (m_md_left > 0) m_md_left--;
            else if ((LAT >= 2) && bus.ID_EX_muldiv) m_md_left = LAT - 1;
        end
    endtask

    // Inputs are applied just after a falling edge; outputs are sampled
    // before the next rising edge, then the model advances at that edge.
    task automatic step();
        #1;
        model_eval();
        check1("pc_write",     bus.pc_write,     e_pc);
        check1("IF_ID_write",  bus.IF_ID_write,  e_ifid_w);
        check1("IF_ID_flush",  bus.IF_ID_flush,  e_flush);
        check1("ID_EX_bubble", bus.ID_EX_bubble, e_idex_bub);
        check1("ID_EX_write",  bus.ID_EX_write,  e_idex_w);
        check1("EX_ME_bubble", bus.EX_ME_bubble, e_exme_bub);
        check1("muldiv_busy",  bus.muldiv_busy,  e_busy);
        checkn("stall_cycles", 32'(bus.stall_cycles), 32'(m_stalls));
        checkn("stall_cycles_sat", 32'(bus4.stall_cycles), 32'((m_stalls > 15) ? 15 : m_stalls));
        @(posedge clk);
        model_advance();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        bus.IF_ID_rs             = 5'd0;
        bus.IF_ID_rt             = 5'd0;
        bus.IF_ID_uses_rt        = 1'b0;
        bus.IF_ID_is_branch      = 1'b0;
        bus.ID_branch_taken      = 1'b0;
        bus.ID_jump              = 1'b0;
        bus.ID_EX_mem_read       = 1'b0;
        bus.ID_EX_reg_write      = 1'b0;
        bus.ID_EX_write_register = 5'd0;
        bus.ID_EX_muldiv         = 1'b0;
        bus.EX_ME_mem_read       = 1'b0;
        bus.EX_ME_write_register = 5'd0;
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        @(negedge clk);
        // Reset: pass-through controls, counter cleared
        step();
        step();
        reset = 1'b0;
        checkn("reset_cnt", 32'(bus.stall_cycles), 32'd0);

        // Load-use on rs
        bus.ID_EX_mem_read = 1'b1; bus.ID_EX_reg_write = 1'b1;
        bus.ID_EX_write_register = 5'd8; bus.IF_ID_rs = 5'd8;
        #1 check1("lu_pc_write", bus.pc_write, 1'b0);
        step();
        clear_inputs();
        bus.IF_ID_rs = 5'd8;
        step();
        checkn("lu_cnt", 32'(bus.stall_cycles), 32'd1);

        // $zero destination never stalls
        bus.ID_EX_mem_read = 1'b1; bus.ID_EX_write_register = 5'd0; bus.IF_ID_rs = 5'd0;
        step();
        checkn("zero_cnt", 32'(bus.stall_cycles), 32'd1);

        // rt only matters when read
        bus.ID_EX_write_register = 5'd9; bus.IF_ID_rs = 5'd3; bus.IF_ID_rt = 5'd9;
        bus.IF_ID_uses_rt = 1'b0;
        step();
        checkn("rt_unused_cnt", 32'(bus.stall_cycles), 32'd1);
        bus.IF_ID_uses_rt = 1'b1;
        step();
        checkn("rt_used_cnt", 32'(bus.stall_cycles), 32'd2);

        // Load followed by dependent taken beq: two stall cycles then flush
        clear_inputs();
        bus.ID_EX_mem_read = 1'b1; bus.ID_EX_reg_write = 1'b1; bus.ID_EX_write_register = 5'd5;
        bus.IF_ID_is_branch = 1'b1; bus.ID_branch_taken = 1'b1; bus.IF_ID_rs = 5'd5;
        step();
        bus.ID_EX_mem_read = 1'b0; bus.ID_EX_reg_write = 1'b0; bus.ID_EX_write_register = 5'd0;
        bus.EX_ME_mem_read = 1'b1; bus.EX_ME_write_register = 5'd5;
        #1 check1("brld_stall", bus.pc_write, 1'b0);
        step();
        bus.EX_ME_mem_read = 1'b0; bus.EX_ME_write_register = 5'd0;
        #1 check1("beq_flush", bus.IF_ID_flush, 1'b1);
        step();
        checkn("beq_cnt", 32'(bus.stall_cycles), 32'd4);

        // ALU op followed by dependent branch: one stall cycle
        clear_inputs();
        bus.ID_EX_reg_write = 1'b1; bus.ID_EX_write_register = 5'd12;
        bus.IF_ID_is_branch = 1'b1; bus.IF_ID_rt = 5'd12; bus.IF_ID_uses_rt = 1'b1;
        step();
        bus.ID_EX_reg_write = 1'b0; bus.ID_EX_write_register = 5'd0;
        step();
        checkn("bralu_cnt", 32'(bus.stall_cycles), 32'd5);

        // Mult/div pulse: three frozen cycles, then the final EX cycle advances
        clear_inputs();
        bus.ID_EX_muldiv = 1'b1;
        step();
        bus.ID_EX_muldiv = 1'b0;
        step();
        step();
        #1 check1("md_last_pc", bus.pc_write, 1'b1);
        check1("md_last_busy", bus.muldiv_busy, 1'b1);
        step();
        check1("md_done_busy", bus.muldiv_busy, 1'b0);
        checkn("md_cnt", 32'(bus.stall_cycles), 32'd8);

        // Mult/div with pending load-use and taken branch / jump in ID
        clear_inputs();
        bus.ID_EX_muldiv = 1'b1;
        bus.ID_EX_mem_read = 1'b1; bus.ID_EX_write_register = 5'd6; bus.IF_ID_rs = 5'd6;
        bus.IF_ID_is_branch = 1'b1; bus.ID_branch_taken = 1'b1; bus.ID_jump = 1'b1;
        #1 check1("md_no_bubble", bus.ID_EX_bubble, 1'b0);
        for (int i = 0; i < 4; i++) step();
        bus.ID_EX_muldiv = 1'b0; bus.ID_EX_mem_read = 1'b0; bus.ID_EX_write_register = 5'd0;
        #1 check1("md_after_flush", bus.IF_ID_flush, 1'b1);
        step();

        // Reset in the middle of a mult/div occupancy
        clear_inputs();
        bus.ID_EX_muldiv = 1'b1;
        step();
        bus.ID_EX_muldiv = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        check1("rst_md_busy", bus.muldiv_busy, 1'b0);
        checkn("rst_md_cnt", 32'(bus.stall_cycles), 32'd0);
        step();

        // Saturation of the 4-bit counter after 20 stall cycles
        bus.ID_EX_mem_read = 1'b1; bus.ID_EX_write_register = 5'd7; bus.IF_ID_rs = 5'd7;
        for (int i = 0; i < 20; i++) step();
        checkn("sat_cnt", 32'(bus4.stall_cycles), 32'd15);
        checkn("wide_cnt", 32'(bus.stall_cycles), 32'd20);

        // Randomized traffic over a small register set to provoke matches
        for (int i = 0; i < 1500; i++) begin
            reset                    = ($urandom_range(0, 99) < 2);
            bus.IF_ID_rs             = 5'($urandom_range(0, 3));
            bus.IF_ID_rt             = 5'($urandom_range(0, 3));
            bus.IF_ID_uses_rt        = 1'($urandom_range(0, 1));
            bus.IF_ID_is_branch      = 1'($urandom_range(0, 1));
            bus.ID_branch_taken      = 1'($urandom_range(0, 1));
            bus.ID_jump              = ($urandom_range(0, 3) == 0);
            bus.ID_EX_mem_read       = 1'($urandom_range(0, 1));
            bus.ID_EX_reg_write      = 1'($urandom_range(0, 1));
            bus.ID_EX_write_register = 5'($urandom_range(0, 3));
            bus.ID_EX_muldiv         = ($urandom_range(0, 7) == 0);
            bus.EX_ME_mem_read       = 1'($urandom_range(0, 1));
            bus.EX_ME_write_register = 5'($urandom_range(0, 3));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
